// File: rtl/uart_link_pkg.sv
// UART control link shared definitions.
// Used by the TX framer and the RX frame parser.
package uart_link_pkg;

  localparam int PAYLOAD_BITS = 8;
  localparam int FRAME_BYTES = 3;
  localparam logic [7:0] TERMINATOR = 8'h0A;

  typedef enum logic {
    F_IDLE,
    F_SEND
  } frame_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  function automatic int cycles_per_bit(
    input int clk_hz,
    input int bit_rate
  );
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_frame_tx_serializer.sv
// 8N1 byte serializer with baud timing.
// Chains straight into the next byte when started on the stop bit.
module uart_byte_serializer #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_uart,
  input  logic [DATA_BITS-1:0] byte_in,
  input  logic                 byte_start,
  output logic                 txd,
  output logic                 byte_done,
  output logic                 ser_busy
);
  import uart_link_pkg::*;

  localparam int BW = $clog2(CYCLES_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  byte_state_t state, state_n;
  logic [BW-1:0] baud;
  logic [2:0] bitc;
  logic [2:0] bitc_nx;
  logic [DATA_BITS-1:0] shreg;
  logic bit_end;
  logic load;

  assign bit_end = (baud == BAUD_LAST);
  assign bitc_nx = bitc + 3'd1;
  assign ser_busy = (state != B_IDLE);

  // Next-state, byte_done and load decode.
  always_comb begin
    state_n = state;
    byte_done = 1'b0;
    load = 1'b0;
    unique case (state)
      B_IDLE: begin
        if (byte_start) begin
          state_n = B_START;
          load = 1'b1;
        end
      end
      B_START: begin
        if (bit_end) state_n = B_DATA;
      end
      B_DATA: begin
        if (bit_end && bitc == BIT_LAST)
          state_n = B_STOP;
      end
      B_STOP: begin
        if (bit_end) begin
          byte_done = 1'b1;
          if (byte_start) begin
            state_n = B_START;
            load = 1'b1;
          end else begin
            state_n = B_IDLE;
          end
        end
      end
      default: state_n = B_IDLE;
    endcase
  end

  // State, counters and the registered line driver.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      state <= B_IDLE;
      baud <= '0;
      bitc <= '0;
      shreg <= '0;
      txd <= 1'b1;
    end else begin
      state <= state_n;
      if (state == B_IDLE || bit_end)
        baud <= '0;
      else
        baud <= baud + 1'b1;
      if (load) begin
        shreg <= byte_in;
        bitc <= '0;
        txd <= 1'b0;
      end else if (bit_end) begin
        unique case (state)
          B_START: txd <= shreg[0];
          B_DATA: begin
            if (bitc == BIT_LAST) begin
              txd <= 1'b1;
            end else begin
              txd <= shreg[bitc_nx];
              bitc <= bitc_nx;
            end
          end
          B_STOP: txd <= 1'b1;
          default: txd <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: 24-bit word as 3 bytes MSB first plus terminator.
// One-deep holding buffer lets back-to-back frames stream without a gap.
module uart_frame_tx #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BIT_RATE = 9600,
  parameter int PAYLOAD_BITS = uart_link_pkg::PAYLOAD_BITS,
  parameter int FRAME_BYTES = uart_link_pkg::FRAME_BYTES,
  parameter logic [PAYLOAD_BITS-1:0] TERMINATOR =
    uart_link_pkg::TERMINATOR
) (
  input  logic clk,
  input  logic reset_uart,
  input  logic [FRAME_BYTES*PAYLOAD_BITS-1:0] frame_data,
  input  logic frame_valid,
  output logic frame_ready,
  output logic uart_tx,
  output logic tx_busy,
  output logic [15:0] frames_sent
);
  import uart_link_pkg::*;

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int WW = FRAME_BYTES * PAYLOAD_BITS;
  localparam int IW = $clog2(FRAME_BYTES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BYTES);

  frame_state_t fstate, fstate_n;
  logic [IW-1:0] idx, idx_n;
  logic [WW-1:0] work_q, hold_q;
  logic hold_full, hold_full_n;
  logic ready_q;
  logic take, accept, cnt_inc;
  logic [15:0] frames_q, frames_n;
  logic [PAYLOAD_BITS-1:0] byte_in;
  logic byte_start, byte_done, ser_busy, txd;

  function automatic logic [PAYLOAD_BITS-1:0] pick(
    input logic [WW-1:0] w,
    input logic [IW-1:0] i
  );
    if (i == IDX_LAST) return TERMINATOR;
    return w[WW - PAYLOAD_BITS - int'(i) * PAYLOAD_BITS
             +: PAYLOAD_BITS];
  endfunction

  assign frame_ready = ready_q & ~reset_uart;
  assign accept = frame_valid & frame_ready;
  assign tx_busy = (fstate != F_IDLE) | hold_full;
  assign uart_tx = txd;
  assign frames_sent = frames_q;

  // Frame sequencing; the next byte is presented on byte_done so it chains.
  always_comb begin
    fstate_n = fstate;
    idx_n = idx;
    take = 1'b0;
    cnt_inc = 1'b0;
    byte_start = 1'b0;
    byte_in = pick(work_q, idx);
    unique case (fstate)
      F_IDLE: begin
        if (hold_full) begin
          take = 1'b1;
          idx_n = '0;
          fstate_n = F_SEND;
        end
      end
      F_SEND: begin
        if (!ser_busy) begin
          byte_start = 1'b1;
        end else if (byte_done) begin
          if (idx == IDX_LAST) begin
            cnt_inc = 1'b1;
            if (hold_full) begin
              take = 1'b1;
              idx_n = '0;
              byte_start = 1'b1;
              byte_in = pick(hold_q, '0);
            end else begin
              fstate_n = F_IDLE;
            end
          end else begin
            idx_n = idx + 1'b1;
            byte_start = 1'b1;
            byte_in = pick(work_q, idx + 1'b1);
          end
        end
      end
      default: fstate_n = F_IDLE;
    endcase
    hold_full_n = accept | (hold_full & ~take);
    frames_n = frames_q + {15'd0, cnt_inc};
  end

  // Controller state, holding/working registers and frame counter.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      fstate <= F_IDLE;
      idx <= '0;
      work_q <= '0;
      hold_q <= '0;
      hold_full <= 1'b0;
      ready_q <= 1'b1;
      frames_q <= '0;
    end else begin
      fstate <= fstate_n;
      idx <= idx_n;
      hold_full <= hold_full_n;
      ready_q <= ~hold_full_n;
      frames_q <= frames_n;
      if (take) work_q <= hold_q;
      if (accept) hold_q <= frame_data;
    end
  end

  uart_byte_serializer #(
    .CYCLES_PER_BIT(CPB),
    .DATA_BITS(PAYLOAD_BITS)
  ) u_ser (
    .clk(clk),
    .reset_uart(reset_uart),
    .byte_in(byte_in),
    .byte_start(byte_start),
    .txd(txd),
    .byte_done(byte_done),
    .ser_busy(ser_busy)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx at 4 cycles per bit.
// Line decoder pops expected bytes from a scoreboard queue.
module tb_uart_frame_tx;
  localparam int CPB = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int FRAME_CYC = 4 * BYTE_CYC;

  logic clk = 1'b0;
  logic reset_uart = 1'b1;
  logic [23:0] frame_data = '0;
  logic frame_valid = 1'b0;
  logic frame_ready;
  logic uart_tx;
  logic tx_busy;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;
  int edges = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  logic [15:0] exp_frames = '0;
  bit seen_f, seen_z;

  uart_frame_tx #(
    .CLK_HZ(40),
    .BIT_RATE(10)
  ) dut (
    .clk(clk),
    .reset_uart(reset_uart),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edges++;
  end

  initial begin : monitor
    bit act;
    int cnt;
    logic [7:0] sh;
    logic [7:0] want;
    act = 0;
    cnt = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (reset_uart !== 1'b0) begin
        act = 0;
      end else if (!act) begin
        if (uart_tx === 1'b0) begin
          act = 1;
          cnt = 0;
          start_q.push_back(edges);
        end
      end else begin
        cnt++;
        if (cnt == 2) begin
          checks++;
          if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL start_bit got %b want 0", uart_tx);
          end
        end else if (cnt >= 6 && cnt <= 34 && cnt % 4 == 2) begin
          sh[(cnt - 6) / 4] = uart_tx;
        end else if (cnt == 38) begin
          act = 0;
          checks++;
          if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit got %b want 1", uart_tx);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_extra got %h want none", sh);
          end else begin
            want = exp_q.pop_front();
            if (sh !== want) begin
              errors++;
              $display("FAIL rx_byte got %h want %h", sh, want);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [23:0] d);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    int n = 0;
    while (frames_sent !== target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (frames_sent !== target) begin
      errors++;
      $display("FAIL frames_wait got %h want %h", frames_sent, target);
    end
  endtask

  task automatic test_reset();
    reset_uart = 1'b1;
    tick();
    tick();
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset got %b want 0", frame_ready);
    end
    reset_uart = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_line got tx=%b busy=%b want 1 0", uart_tx, tx_busy);
    end
    checks++;
    if (frames_sent !== 16'h0) begin
      errors++;
      $display("FAIL reset_count got %h want 0000", frames_sent);
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", frame_ready);
    end
    exp_frames = '0;
  endtask

  task automatic test_basic();
    int acc;
    start_q.delete();
    push_frame(24'h123456);
    frame_data = 24'h123456;
    frame_valid = 1'b1;
    tick();
    acc = edges;
    frame_valid = 1'b0;
    checks++;
    if (frame_ready !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_flags got rdy=%b busy=%b want 0 1", frame_ready, tx_busy);
    end
    tick();
    checks++;
    if (frame_ready !== 1'b1 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL n1_state got rdy=%b tx=%b want 1 1", frame_ready, uart_tx);
    end
    tick();
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL start_edge got %b want 0", uart_tx);
    end
    exp_frames++;
    wait_frames(exp_frames, 300);
    checks++;
    if (edges !== acc + 2 + FRAME_CYC) begin
      errors++;
      $display("FAIL frame_len got %0d want %0d", edges - acc, 2 + FRAME_CYC);
    end
    checks++;
    if (start_q.size() != 4 || start_q[0] != acc + 2 || start_q[3] - start_q[0] != 3 * BYTE_CYC) begin
      errors++;
      $display("FAIL byte_starts got n=%0d want 4 evenly spaced", start_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left got %0d want 0", exp_q.size());
    end
    tick();
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got %b want 0", tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int n;
    start_q.delete();
    push_frame(24'hA5A5A5);
    frame_data = 24'hA5A5A5;
    frame_valid = 1'b1;
    tick();
    acc = edges;
    push_frame(24'h000000);
    frame_data = 24'h000000;
    tick();
    tick();
    frame_valid = 1'b0;
    n = 0;
    while (frame_ready === 1'b0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (edges !== acc + 2 + FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_ready got %0d want %0d", edges - acc, 2 + FRAME_CYC);
    end
    checks++;
    if (frames_sent !== exp_frames + 16'd1) begin
      errors++;
      $display("FAIL b2b_mid got %h want %h", frames_sent, exp_frames + 16'd1);
    end
    exp_frames += 16'd2;
    wait_frames(exp_frames, 400);
    checks++;
    if (edges !== acc + 2 + 2 * FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_len got %0d want %0d", edges - acc, 2 + 2 * FRAME_CYC);
    end
    checks++;
    if (start_q.size() != 8 || start_q[4] - start_q[3] != BYTE_CYC) begin
      errors++;
      $display("FAIL b2b_gap got n=%0d want 8 with no gap", start_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    push_frame(24'h111111);
    frame_data = 24'h111111;
    frame_valid = 1'b1;
    tick();
    push_frame(24'h222222);
    frame_data = 24'h222222;
    tick();
    tick();
    n = 0;
    while (frame_ready !== 1'b1 && n < 400) begin
      frame_data = 24'($urandom);
      tick();
      n++;
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got %b want 1", frame_ready);
    end
    push_frame(24'h3C3C3C);
    frame_data = 24'h3C3C3C;
    tick();
    frame_valid = 1'b0;
    exp_frames += 16'd3;
    wait_frames(exp_frames, 700);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    start_q.delete();
    push_frame(24'h5500AA);
    frame_data = 24'h5500AA;
    frame_valid = 1'b1;
    tick();
    frame_data = 24'h777777;
    tick();
    tick();
    frame_valid = 1'b0;
    repeat (BYTE_CYC + 20) tick();
    checks++;
    if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_line got tx=%b busy=%b want 0 1", uart_tx, tx_busy);
    end
    reset_uart = 1'b1;
    #1;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rdy_rst got %b want 0", frame_ready);
    end
    tick();
    reset_uart = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || frames_sent !== 16'h0 || frame_ready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got tx=%b cnt=%h rdy=%b busy=%b want 1 0000 1 0", uart_tx, frames_sent, frame_ready, tx_busy);
    end
    exp_q.delete();
    exp_frames = '0;
    begin
      int bad = 0;
      repeat (100) begin
        tick();
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL mid_discard got %0d busy cycles want 0", bad);
      end
    end
    start_q.delete();
    push_frame(24'h123456);
    frame_data = 24'h123456;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    exp_frames = 16'd1;
    wait_frames(exp_frames, 300);
    checks++;
    if (start_q.size() != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_after got starts=%0d left=%0d want 4 0", start_q.size(), exp_q.size());
    end
  endtask

  task automatic tick_w();
    tick();
    if (frames_sent === 16'hFFFF) seen_f = 1;
    if (frames_sent === 16'h0000 && seen_f) seen_z = 1;
  endtask

  task automatic test_wrap();
    logic [23:0] d [3];
    int n;
    d[0] = 24'hFEDCBA;
    d[1] = 24'h0F0F0F;
    d[2] = 24'h818181;
    seen_f = 0;
    seen_z = 0;
    @(negedge clk);
    force dut.frames_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frames_q;
    #1;
    checks++;
    if (frames_sent !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_preload got %h want fffe", frames_sent);
    end
    for (int k = 0; k < 3; k++) begin
      push_frame(d[k]);
      frame_data = d[k];
      frame_valid = 1'b1;
      n = 0;
      while (frame_ready !== 1'b1 && n < 400) begin
        tick_w();
        n++;
      end
      tick_w();
    end
    frame_valid = 1'b0;
    n = 0;
    while (frames_sent !== 16'h0001 && n < 800) begin
      tick_w();
      n++;
    end
    checks++;
    if (frames_sent !== 16'h0001 || !seen_f || !seen_z) begin
      errors++;
      $display("FAIL wrap got %h ffff=%0d 0000=%0d want 0001 1 1", frames_sent, seen_f, seen_z);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_idle();
    repeat (1000) begin
      tick();
      checks++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || frame_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle got tx=%b busy=%b rdy=%b want 1 0 1", uart_tx, tx_busy, frame_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_left got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
